// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
//
// Control FSM for a classic multicycle datapath. Each instruction walks
// FETCH -> DECODE -> EXEC [-> MEM] [-> WB] -> FETCH. In DECODE it latches the
// opcode and function field. Everything after that, sequencing and datapath
// selects alike, comes from the latched copy, so op_code/func may change
// once DECODE has passed.
//
// Optional feature: define MULTICYCLE_MDU_EN to give multiply/divide ops
// (op 0, func 24/25/26) an EXEC stage MDU_LAT cycles long. Without the macro
// they finish in a single EXEC cycle like any other non-writeback op.
//
// Parameters
//   OP_W     opcode width (>= 6)
//   FUNC_W   function-field width (>= 6)
//   MDU_LAT  EXEC cycles for multiply/divide ops when MULTICYCLE_MDU_EN is set
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   en                  run enable, looked at only in FETCH
//   op_code, func       instruction fields, sampled in DECODE
//   mem_ready           memory handshake for FETCH and MEM accesses
//   alu_op              latched opcode
//   reg_dst, alu_src,
//   branch, mem_to_reg  datapath selects (branch is a one-cycle EXEC strobe)
//   mem_read, mem_write,
//   ir_write, pc_write,
//   reg_write           datapath strobes
//   busy                high everywhere except idle FETCH (en low)
//   instr_done          one-cycle pulse in an instruction's last cycle
// ----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OP_W    = 6,
    parameter int FUNC_W  = 6,
    parameter int MDU_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [OP_W-1:0]   op_code,
    input  logic [FUNC_W-1:0] func,
    input  logic              mem_ready,
    output logic [OP_W-1:0]   alu_op,
    output logic              reg_dst,
    output logic              alu_src,
    output logic              branch,
    output logic              mem_to_reg,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic              busy,
    output logic              instr_done
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    // An out-of-range MDU_LAT shows up as this block in the elaborated
    // hierarchy. It also keeps the parameter referenced when the MDU
    // feature is compiled out.
    if (MDU_LAT < 1) begin : g_mdu_lat_invalid
    end

    // ------------------------------------------------------------------
    // Decode helpers. Constants are zero-extended to the field widths.
    // ------------------------------------------------------------------
    function automatic logic op_is(input logic [OP_W-1:0] op, input int value);
        return op == OP_W'(value);
    endfunction

    function automatic logic fn_is(input logic [FUNC_W-1:0] fn, input int value);
        return fn == FUNC_W'(value);
    endfunction

    function automatic logic is_branch_op(input logic [OP_W-1:0] op);
        return op_is(op, 41) || ((op >= OP_W'(48)) && (op <= OP_W'(54)));
    endfunction

    function automatic logic is_mdu_op(input logic [OP_W-1:0] op,
                                       input logic [FUNC_W-1:0] fn);
        return op_is(op, 0) && (fn_is(fn, 24) || fn_is(fn, 25) || fn_is(fn, 26));
    endfunction

    function automatic logic is_alu_src(input logic [OP_W-1:0] op,
                                        input logic [FUNC_W-1:0] fn);
        return (op_is(op, 0) && (fn_is(fn, 0) || fn_is(fn, 2) ||
                                 fn_is(fn, 3) || fn_is(fn, 4)))
            || op_is(op, 8)  || op_is(op, 9)  || op_is(op, 10)
            || op_is(op, 12) || op_is(op, 13) || op_is(op, 14)
            || op_is(op, 15) || op_is(op, 35) || op_is(op, 36)
            || op_is(op, 43);
    endfunction

    // ------------------------------------------------------------------
    // State and latched instruction
    // ------------------------------------------------------------------
    logic [2:0]        state_reg, state_next;
    logic [OP_W-1:0]   op_reg;
    logic [FUNC_W-1:0] func_reg;
    logic              reg_dst_reg, alu_src_reg, mem_to_reg_reg;

    // Instruction classes from the latched fields (drive sequencing)
    logic l_branch, l_load, l_store, l_mdu, l_wb;

    assign l_branch = is_branch_op(op_reg);
    assign l_load   = op_is(op_reg, 35);
    assign l_store  = op_is(op_reg, 43);
    assign l_mdu    = is_mdu_op(op_reg, func_reg);
    assign l_wb     = !(op_is(op_reg, 1) || op_is(op_reg, 3) ||
                        l_store || l_branch || l_mdu);

    // Raw strobes before reset gating
    logic mem_read_c, mem_write_c, ir_write_c, pc_write_c;
    logic reg_write_c, branch_c, done_c;

`ifdef MULTICYCLE_MDU_EN
    localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    logic [CNT_W-1:0] mdu_cnt_reg, mdu_cnt_next;
`endif

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        branch_c    = 1'b0;
        done_c      = 1'b0;
`ifdef MULTICYCLE_MDU_EN
        mdu_cnt_next = mdu_cnt_reg;
`endif
        case (state_reg)
            S_FETCH: begin
                if (en) begin
                    mem_read_c = 1'b1;
                    if (mem_ready) begin
                        ir_write_c = 1'b1;
                        pc_write_c = 1'b1;
                        state_next = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (l_branch) begin
                    branch_c   = 1'b1;
                    done_c     = 1'b1;
                    state_next = S_FETCH;
                end else if (l_load || l_store) begin
                    state_next = S_MEM;
                end
`ifdef MULTICYCLE_MDU_EN
                else if (l_mdu) begin
                    // Stay in EXEC while the counter runs 0..MDU_LAT-1
                    if (mdu_cnt_reg == CNT_W'(MDU_LAT - 1)) begin
                        mdu_cnt_next = '0;
                        done_c       = 1'b1;
                        state_next   = S_FETCH;
                    end else begin
                        mdu_cnt_next = mdu_cnt_reg + CNT_W'(1);
                    end
                end
`endif
                else if (l_wb) begin
                    state_next = S_WB;
                end else begin
                    done_c     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                // Only loads and stores reach MEM, so this split is exclusive
                if (l_load) begin
                    mem_read_c = 1'b1;
                end else begin
                    mem_write_c = 1'b1;
                end
                if (mem_ready) begin
                    if (l_load) begin
                        state_next = S_WB;
                    end else begin
                        done_c     = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_next  = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_FETCH;
            op_reg         <= '0;
            func_reg       <= '0;
            reg_dst_reg    <= 1'b0;
            alu_src_reg    <= 1'b0;
            mem_to_reg_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                op_reg         <= op_code;
                func_reg       <= func;
                reg_dst_reg    <= !(op_is(op_code, 0) || op_is(op_code, 11) ||
                                    is_branch_op(op_code));
                alu_src_reg    <= is_alu_src(op_code, func);
                mem_to_reg_reg <= op_is(op_code, 35);
            end
        end
    end

`ifdef MULTICYCLE_MDU_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt_reg <= '0;
        end else begin
            mdu_cnt_reg <= mdu_cnt_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs. The FETCH-state strobes depend on en, so every combinational
    // output is gated with rst_n to read zero throughout reset.
    // ------------------------------------------------------------------
    assign alu_op     = op_reg;
    assign reg_dst    = reg_dst_reg;
    assign alu_src    = alu_src_reg;
    assign mem_to_reg = mem_to_reg_reg;
    assign mem_read   = rst_n & mem_read_c;
    assign mem_write  = rst_n & mem_write_c;
    assign ir_write   = rst_n & ir_write_c;
    assign pc_write   = rst_n & pc_write_c;
    assign reg_write  = rst_n & reg_write_c;
    assign branch     = rst_n & branch_c;
    assign instr_done = rst_n & done_c;
    assign busy       = rst_n & !((state_reg == S_FETCH) && !en);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench for multicycle_control_unit. Each instruction is started
// from idle FETCH with en pulsed for one cycle. The bench traces strobes
// cycle by cycle until instr_done and compares the trace with hand-computed
// latencies and selects. It then checks reset behaviour both at start-up
// and in the middle of a load's MEM phase.
// ----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int OP_W    = 6;
    localparam int FUNC_W  = 6;
    localparam int MDU_LAT = 8;

`ifdef MULTICYCLE_MDU_EN
    localparam int MDU_DONE = 2 + MDU_LAT;   // fetch + decode + MDU_LAT exec
`else
    localparam int MDU_DONE = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [OP_W-1:0]   op_code = '0;
    logic [FUNC_W-1:0] func = '0;
    logic              mem_ready = 1'b0;
    logic [OP_W-1:0]   alu_op;
    logic reg_dst, alu_src, branch, mem_to_reg, mem_read, mem_write;
    logic ir_write, pc_write, reg_write, busy, instr_done;

    multicycle_control_unit #(
        .OP_W(OP_W), .FUNC_W(FUNC_W), .MDU_LAT(MDU_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op_code(op_code), .func(func),
        .mem_ready(mem_ready), .alu_op(alu_op), .reg_dst(reg_dst),
        .alu_src(alu_src), .branch(branch), .mem_to_reg(mem_to_reg),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .busy(busy),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Trace results of the last instruction
    int done_cyc, rw_cnt, rw_cyc, br_cnt, br_cyc, mr_cnt, mw_cnt;
    int busy_cnt, iw_cnt, iw_cyc, pw_cnt, both_cnt, post_busy, post_act;
    logic s_reg_dst, s_alu_src, s_mem_to_reg;
    logic [OP_W-1:0] s_alu_op;

    // Drives one instruction. mem_ready is low for wait_cycles starting at
    // cycle 4 (the MEM cycle for loads/stores) and high otherwise.
    task automatic run_instr(input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] fn,
                             input int wait_cycles);
        int c;
        done_cyc = 0; rw_cnt = 0; rw_cyc = 0; br_cnt = 0; br_cyc = 0;
        mr_cnt = 0; mw_cnt = 0; busy_cnt = 0; iw_cnt = 0; iw_cyc = 0;
        pw_cnt = 0; both_cnt = 0;
        s_reg_dst = 1'b0; s_alu_src = 1'b0; s_mem_to_reg = 1'b0; s_alu_op = '0;
        c = 0;
        while (done_cyc == 0 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
            op_code   = op;
            func      = fn;
            en        = (c == 1);
            mem_ready = !(c >= 4 && c < 4 + wait_cycles);
            #3;
            if (ir_write) begin iw_cnt++; iw_cyc = c; end
            if (pc_write) pw_cnt++;
            if (mem_read && c > 1) mr_cnt++;
            if (mem_write) mw_cnt++;
            if (mem_read && mem_write) both_cnt++;
            if (reg_write) begin rw_cnt++; rw_cyc = c; end
            if (branch) begin br_cnt++; br_cyc = c; end
            if (busy) busy_cnt++;
            if (instr_done) begin
                done_cyc     = c;
                s_reg_dst    = reg_dst;
                s_alu_src    = alu_src;
                s_mem_to_reg = mem_to_reg;
                s_alu_op     = alu_op;
            end
        end
        // One more cycle with en low: the FSM must be back in idle FETCH
        @(posedge clk);
        #1;
        en = 1'b0;
        mem_ready = 1'b1;
        #3;
        post_busy = int'(busy);
        post_act  = int'(mem_read | mem_write | reg_write | instr_done | ir_write | branch);
        $display("instr op=%0d func=%0d wait=%0d done_cycle=%0d reg_write=%0d branch=%0d mem_rd=%0d mem_wr=%0d",
                 op, fn, wait_cycles, done_cyc, rw_cnt, br_cnt, mr_cnt, mw_cnt);
    endtask

    task automatic run_and_check(input string tag, input int op, input int fn, input int wt,
                                 input int e_done, input int e_rw, input int e_br,
                                 input int e_mr, input int e_mw,
                                 input int e_rd, input int e_as, input int e_m2r);
        run_instr(OP_W'(op), FUNC_W'(fn), wt);
        check({tag, ".done_cycle"}, done_cyc, e_done);
        check({tag, ".ir_write_cycle"}, iw_cyc, 1);
        check({tag, ".ir_write_count"}, iw_cnt, 1);
        check({tag, ".pc_write_count"}, pw_cnt, 1);
        check({tag, ".reg_write_count"}, rw_cnt, e_rw);
        check({tag, ".reg_write_cycle"}, rw_cyc, (e_rw != 0) ? e_done : 0);
        check({tag, ".branch_count"}, br_cnt, e_br);
        check({tag, ".branch_cycle"}, br_cyc, (e_br != 0) ? 3 : 0);
        check({tag, ".mem_read_cycles"}, mr_cnt, e_mr);
        check({tag, ".mem_write_cycles"}, mw_cnt, e_mw);
        check({tag, ".rd_wr_overlap"}, both_cnt, 0);
        check({tag, ".busy_cycles"}, busy_cnt, e_done);
        check({tag, ".reg_dst"}, s_reg_dst, e_rd);
        check({tag, ".alu_src"}, s_alu_src, e_as);
        check({tag, ".mem_to_reg"}, s_mem_to_reg, e_m2r);
        check({tag, ".alu_op"}, s_alu_op, op);
        check({tag, ".idle_busy"}, post_busy, 0);
        check({tag, ".idle_strobes"}, post_act, 0);
    endtask

    initial begin
        int idle_hits;

        // Reset held with en and mem_ready high: everything must read zero
        rst_n = 1'b0; en = 1'b1; mem_ready = 1'b1; op_code = 6'd35;
        #12;
        check("reset.mem_read", mem_read, 0);
        check("reset.ir_write", ir_write, 0);
        check("reset.pc_write", pc_write, 0);
        check("reset.busy", busy, 0);
        check("reset.alu_op", alu_op, 0);
        check("reset.instr_done", instr_done, 0);
        check("reset.reg_write", reg_write, 0);
        @(posedge clk);
        #1;
        en = 1'b0;
        rst_n = 1'b1;

        // Idle FETCH: en low, mem_ready high, no activity
        idle_hits = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #4;
            if (busy || mem_read || ir_write || pc_write) idle_hits++;
        end
        check("idle.activity", idle_hits, 0);

        //             tag        op fn wt done rw br mr mw rd as m2r
        run_and_check("rtype",     0, 32, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        run_and_check("load_w3",  35,  0, 3, 8, 1, 0, 4, 0, 1, 1, 1);
        run_and_check("load_w0",  35,  0, 0, 5, 1, 0, 1, 0, 1, 1, 1);
        run_and_check("store_w0", 43,  0, 0, 4, 0, 0, 0, 1, 1, 1, 0);
        run_and_check("store_w2", 43,  0, 2, 6, 0, 0, 0, 3, 1, 1, 0);
        run_and_check("br50",     50,  0, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        run_and_check("br41",     41,  0, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        run_and_check("br48",     48,  0, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        run_and_check("br54",     54,  0, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        run_and_check("op47",     47,  0, 0, 4, 1, 0, 0, 0, 1, 0, 0);
        run_and_check("op55",     55,  0, 0, 4, 1, 0, 0, 0, 1, 0, 0);
        run_and_check("addi8",     8,  0, 0, 4, 1, 0, 0, 0, 1, 1, 0);
        run_and_check("op36",     36,  0, 0, 4, 1, 0, 0, 0, 1, 1, 0);
        run_and_check("op16",     16,  0, 0, 4, 1, 0, 0, 0, 1, 0, 0);
        run_and_check("op1",       1,  0, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        run_and_check("op3",       3,  0, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        run_and_check("op11",     11,  0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        run_and_check("r_fn0",     0,  0, 0, 4, 1, 0, 0, 0, 0, 1, 0);
        run_and_check("r_fn5",     0,  5, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        run_and_check("mdu24",     0, 24, 0, MDU_DONE, 0, 0, 0, 0, 0, 0, 0);
        run_and_check("mdu26",     0, 26, 0, MDU_DONE, 0, 0, 0, 0, 0, 0, 0);
        run_and_check("r_fn27",    0, 27, 0, 4, 1, 0, 0, 0, 0, 0, 0);

        // Reset asserted while a load waits in MEM
        @(posedge clk); #1; en = 1'b1; op_code = 6'd35; func = '0; mem_ready = 1'b1; // FETCH
        @(posedge clk); #1; en = 1'b0;                                              // DECODE
        @(posedge clk); #1;                                                         // EXEC
        @(posedge clk); #1; mem_ready = 1'b0;                                       // MEM
        #2;
        check("midreset.mem_read_before", mem_read, 1);
        check("midreset.alu_op_before", alu_op, 35);
        rst_n = 1'b0;
        #1;
        check("midreset.mem_read", mem_read, 0);
        check("midreset.mem_write", mem_write, 0);
        check("midreset.alu_op", alu_op, 0);
        check("midreset.mem_to_reg", mem_to_reg, 0);
        check("midreset.alu_src", alu_src, 0);
        check("midreset.reg_dst", reg_dst, 0);
        check("midreset.busy", busy, 0);
        check("midreset.reg_write", reg_write, 0);
        en = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("midreset.en_gated_mem_read", mem_read, 0);
        check("midreset.en_gated_busy", busy, 0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_hits = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            if (busy || mem_read || mem_write || ir_write || reg_write) idle_hits++;
            @(posedge clk);
            #1;
        end
        check("midreset.post_release_activity", idle_hits, 0);
        run_and_check("after_reset", 0, 32, 0, 4, 1, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OP_W, default 6, opcode width (>=6); opcode constants below are zero-extended to OP_W.
REQ-002 Parameter FUNC_W, default 6, function-field width (>=6); func constants are zero-extended to FUNC_W.
REQ-003 Parameter MDU_LAT, default 8, EXEC-stage cycles for multiply/divide ops (>=1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  run enable; sampled only in FETCH.
REQ-007 op_code  input  OP_W  opcode of instruction register; sampled in DECODE.
REQ-008 func  input  FUNC_W  function field; sampled in DECODE.
REQ-009 mem_ready  input  1  memory handshake; completes the current memory access.
REQ-010 alu_op  output  OP_W  registered copy of latched opcode.
REQ-011 reg_dst, alu_src, branch, mem_to_reg  output  1 each  datapath selects, registered decode.
REQ-012 mem_read, mem_write, ir_write, pc_write, reg_write  output  1 each  datapath strobes.
REQ-013 busy  output  1  high in every state except idle FETCH.
REQ-014 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.

Function
REQ-015 States: FETCH, DECODE, EXEC, MEM, WB (plus MDU count within EXEC); encoding is free.
REQ-016 FETCH: while en=1, mem_read=1; on mem_ready=1, ir_write=1 and pc_write=1 for that cycle only, next DECODE; en=0 -> stay, busy=0, no strobes.
REQ-017 DECODE: latch op_code/func into internal registers; drive decode outputs from the latched values until the next DECODE; next EXEC.
REQ-018 Decode classes: branch = op 41 or 48..54; load = op 35; store = op 43; mdu = op 0 with func 24, 25 or 26.
REQ-019 reg_dst=1 unless op is 0, 11, or branch class.
REQ-020 alu_src=1 for op 0 with func 0/2/3/4, and for op 8, 9, 10, 12, 13, 14, 15, 35, 36, 43; else 0.
REQ-021 Writeback class = NOT (op 1, op 3, store, branch, mdu).
REQ-022 mem_to_reg=1 only for load.
REQ-023 EXEC: branch -> branch=1 one cycle, instr_done, next FETCH; load/store -> MEM; mdu -> see REQ-030; writeback class -> WB; other -> instr_done, next FETCH.
REQ-024 MEM: load holds mem_read=1, store holds mem_write=1, until mem_ready=1; then load -> WB, store -> instr_done, FETCH.
REQ-025 WB: reg_write=1 exactly one cycle, instr_done, next FETCH.
REQ-026 Latencies with mem_ready constantly 1: R/I ALU 4 cycles, load 5, store 4, branch 3.
REQ-027 mem_ready outside FETCH/MEM is ignored; mem_read and mem_write are never high together.

Reset
REQ-028 rst_n=0 immediately forces FETCH and all outputs to 0, alu_op to 0, MDU counter to 0, regardless of state.
REQ-029 Reset released mid-access: no strobe re-issued until a fresh FETCH with en=1.

Configuration
REQ-030 Macro MULTICYCLE_MDU_EN defined: mdu ops stay in EXEC for MDU_LAT cycles (counter 0..MDU_LAT-1, busy=1), then instr_done, FETCH; reg_write never asserted.
REQ-031 Macro undefined: mdu ops take one EXEC cycle, as the "other" path of REQ-023; MDU_LAT unused, no counter logic.

Verification
REQ-032 Reset, en=1, mem_ready=1, op=0 func=32 -> ir_write/pc_write at cycle 1, reg_write=1 at cycle 4, reg_dst=0, alu_src=0, instr_done cycle 4.
REQ-033 op=35, mem_ready low 3 cycles in MEM -> mem_read held 4 MEM cycles, mem_to_reg=1, reg_write one cycle, then FETCH.
REQ-034 op=43 -> mem_write in MEM, alu_src=1, reg_write never 1; op=50 -> branch=1 in cycle 3, reg_dst=0.
REQ-035 MULTICYCLE_MDU_EN, MDU_LAT=8, op=0 func=24 -> busy 10 cycles after fetch, instr_done once, reg_write=0; macro undefined -> instr_done at cycle 3.
REQ-036 rst_n low in MEM during load -> all outputs 0 asynchronously, FETCH after release; en=0 -> no mem_read, busy=0.
